// File: rtl/ch_readout_collector.sv
// Serial readout receiver for one channel: walks the enabled frame ids in ascending order,
// selects and loads each frame in the channel, shifts it in MSB first and hands it out on valid/ready.
module ch_readout_collector #(
  parameter int WORD_W   = 10,
  parameter int NUM_REGS = 6,
  parameter int TCNT_W   = 3,
  parameter int SETTLE   = 1
) (
  input  logic                SPI_CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [NUM_REGS-1:0] REG_MASK,
  input  logic                CNT_SER,
  output logic [2:0]          SELECT_REG,
  output logic                INST_READOUT,
  output logic [WORD_W-1:0]   WORD_OUT,
  output logic [2:0]          REG_ID,
  output logic                WORD_VALID,
  input  logic                WORD_READY,
  output logic                BUSY,
  output logic                DONE,
  output logic                FMT_ERR
);

  localparam int BIT_W    = $clog2(WORD_W);
  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_SHIFT,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t                state_reg;
  logic [WORD_W-1:0]     sr_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [SETTLE_W-1:0]   settle_cnt_reg;
  logic [NUM_REGS-1:0]   pending_reg;
  logic [2:0]            cur_id_reg;

  logic [2:0]            sel_reg;
  logic                  inst_reg;
  logic [WORD_W-1:0]     word_reg;
  logic [2:0]            id_out_reg;
  logic                  valid_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  fmt_err_reg;

  logic [NUM_REGS-1:0]   scan_src;
  logic [NUM_REGS-1:0]   low_onehot;
  logic [2:0]            next_id;
  logic                  any_pending;
  logic [WORD_W-1:0]     shifted;

  // In IDLE the search runs on the incoming mask so the first frame is chosen on the START edge.
  assign scan_src    = (state_reg == S_IDLE) ? REG_MASK : pending_reg;
  assign any_pending = |scan_src;
  assign shifted     = {sr_reg[WORD_W-2:0], CNT_SER};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_low
      if (gi == 0) begin : g_first
        assign low_onehot[gi] = scan_src[gi];
      end else begin : g_rest
        assign low_onehot[gi] = scan_src[gi] & ~(|scan_src[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    next_id = 3'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (low_onehot[i]) next_id = 3'(i);
    end
  end

  always_ff @(posedge SPI_CLK) begin
    if (RST) begin
      state_reg      <= S_IDLE;
      sr_reg         <= '0;
      bit_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
      pending_reg    <= '0;
      cur_id_reg     <= '0;
      sel_reg        <= '0;
      inst_reg       <= 1'b0;
      word_reg       <= '0;
      id_out_reg     <= '0;
      valid_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      fmt_err_reg    <= 1'b0;
    end else begin
      inst_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (START) begin
            busy_reg    <= 1'b1;
            fmt_err_reg <= 1'b0;
            if (any_pending) begin
              cur_id_reg     <= next_id;
              sel_reg        <= next_id;
              pending_reg    <= scan_src & ~low_onehot;
              settle_cnt_reg <= '0;
              state_reg      <= S_SELECT;
            end else begin
              pending_reg <= '0;
              state_reg   <= S_FINISH;
            end
          end else begin
            busy_reg <= 1'b0;
          end
        end

        S_SELECT: begin
          if (settle_cnt_reg == SETTLE_W'(SETTLE - 1)) begin
            inst_reg  <= 1'b1;
            state_reg <= S_LOAD;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end

        S_LOAD: begin
          bit_cnt_reg <= '0;
          state_reg   <= S_SHIFT;
        end

        S_SHIFT: begin
          sr_reg      <= shifted;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_W'(WORD_W - 1)) begin
            word_reg   <= shifted;
            id_out_reg <= cur_id_reg;
            valid_reg  <= 1'b1;
            // Frame 0 carries trigger_cnt; anything above its field means a corrupted frame.
            if (cur_id_reg == 3'd0 && (|shifted[WORD_W-1:TCNT_W])) begin
              fmt_err_reg <= 1'b1;
            end
            state_reg <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          if (WORD_READY) begin
            valid_reg <= 1'b0;
            if (any_pending) begin
              cur_id_reg     <= next_id;
              sel_reg        <= next_id;
              pending_reg    <= scan_src & ~low_onehot;
              settle_cnt_reg <= '0;
              state_reg      <= S_SELECT;
            end else begin
              state_reg <= S_FINISH;
            end
          end
        end

        S_FINISH: begin
          // BUSY is left high here and drops on the following IDLE edge, so it covers the DONE cycle.
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign SELECT_REG   = sel_reg;
  assign INST_READOUT = inst_reg;
  assign WORD_OUT     = word_reg;
  assign REG_ID       = id_out_reg;
  assign WORD_VALID   = valid_reg;
  assign BUSY         = busy_reg;
  assign DONE         = done_reg;
  assign FMT_ERR      = fmt_err_reg;

endmodule

// File: tb/tb_ch_readout_collector.sv
// Directed bench for ch_readout_collector: a behavioural channel feeds the serial line and a
// scoreboard of expected (REG_ID, WORD_OUT) pairs is checked at every accepted handshake.
module tb_ch_readout_collector;

  logic       SPI_CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [5:0] REG_MASK;
  logic       CNT_SER;
  logic [2:0] SELECT_REG;
  logic       INST_READOUT;
  logic [9:0] WORD_OUT;
  logic [2:0] REG_ID;
  logic       WORD_VALID;
  logic       WORD_READY;
  logic       BUSY;
  logic       DONE;
  logic       FMT_ERR;

  int n_cmp = 0;
  int n_err = 0;
  int inst_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [12:0] sb[$];
  logic [9:0]  ch_vals[8];
  logic [9:0]  ch_sr = '0;

  logic        prev_stall = 1'b0;
  logic [9:0]  held_word;
  logic [2:0]  held_id;
  logic [2:0]  held_sel;

  ch_readout_collector dut (
    .SPI_CLK     (SPI_CLK),
    .RST         (RST),
    .START       (START),
    .REG_MASK    (REG_MASK),
    .CNT_SER     (CNT_SER),
    .SELECT_REG  (SELECT_REG),
    .INST_READOUT(INST_READOUT),
    .WORD_OUT    (WORD_OUT),
    .REG_ID      (REG_ID),
    .WORD_VALID  (WORD_VALID),
    .WORD_READY  (WORD_READY),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .FMT_ERR     (FMT_ERR)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  always @(posedge SPI_CLK) cyc++;

  // Channel: loads the selected counter on INST_READOUT, otherwise shifts out MSB first.
  assign CNT_SER = ch_sr[9];
  always @(posedge SPI_CLK) begin
    if (INST_READOUT) ch_sr <= ch_vals[SELECT_REG];
    else              ch_sr <= {ch_sr[8:0], 1'b0};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard on every accept and checks stability while stalled.
  always @(negedge SPI_CLK) begin
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (INST_READOUT) inst_cnt++;
      if (DONE) done_cnt++;
      if (prev_stall) begin
        chk("stall_word", 32'(WORD_OUT), 32'(held_word));
        chk("stall_id", 32'(REG_ID), 32'(held_id));
        chk("stall_sel", 32'(SELECT_REG), 32'(held_sel));
        chk("stall_inst", 32'(INST_READOUT), 32'(1'b0));
      end
      if (WORD_VALID && WORD_READY) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'(1'b1));
        if (sb.size() > 0) begin
          logic [12:0] e;
          e = sb.pop_front();
          chk("word", 32'({REG_ID, WORD_OUT}), 32'(e));
          $display("word id=%0d data=0x%03h expected id=%0d data=0x%03h", REG_ID, WORD_OUT, e[12:10], e[9:0]);
        end
      end
      prev_stall = WORD_VALID && !WORD_READY;
      held_word  = WORD_OUT;
      held_id    = REG_ID;
      held_sel   = SELECT_REG;
    end
  end

  task automatic tick();
    @(posedge SPI_CLK);
    #1;
  endtask

  task automatic start_readout(input logic [5:0] mask);
    REG_MASK = mask;
    START    = 1'b1;
    tick();
    START     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_until_done(output int done_rel, output int valid_rel);
    valid_rel = -1;
    for (int n = 0; n < 400 && !DONE; n++) begin
      tick();
      if (WORD_VALID && valid_rel < 0) valid_rel = cyc - start_cyc;
    end
    chk("done_seen", 32'(DONE), 32'(1'b1));
    done_rel = cyc - start_cyc;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_sel"},   32'(SELECT_REG), 32'(0));
    chk({pfx, "_inst"},  32'(INST_READOUT), 32'(0));
    chk({pfx, "_word"},  32'(WORD_OUT), 32'(0));
    chk({pfx, "_id"},    32'(REG_ID), 32'(0));
    chk({pfx, "_valid"}, 32'(WORD_VALID), 32'(0));
    chk({pfx, "_busy"},  32'(BUSY), 32'(0));
    chk({pfx, "_done"},  32'(DONE), 32'(0));
    chk({pfx, "_fmt"},   32'(FMT_ERR), 32'(0));
  endtask

  initial begin
    int done_rel, valid_rel, base_inst, base_done, n;

    RST = 1'b1; START = 1'b0; REG_MASK = '0; WORD_READY = 1'b1;
    ch_vals[0] = 10'h005; ch_vals[1] = 10'h155; ch_vals[2] = 10'h2AA; ch_vals[3] = 10'h001;
    ch_vals[4] = 10'h200; ch_vals[5] = 10'h3FF; ch_vals[6] = 10'h000; ch_vals[7] = 10'h000;
    tick(); tick();
    check_reset("por");
    RST = 1'b0;
    tick();

    // Full readout, zero stall
    for (int i = 0; i < 6; i++) sb.push_back({3'(i), ch_vals[i]});
    base_inst = inst_cnt; base_done = done_cnt;
    start_readout(6'h3F);
    run_until_done(done_rel, valid_rel);
    $display("full: first valid at %0d, done at %0d", valid_rel, done_rel);
    chk("full_first_valid", 32'(valid_rel), 32'(12));
    chk("full_done_cycle", 32'(done_rel), 32'(79));
    chk("full_busy_at_done", 32'(BUSY), 32'(1));
    chk("full_fmt", 32'(FMT_ERR), 32'(0));
    tick(); tick();
    chk("full_busy_after", 32'(BUSY), 32'(0));
    chk("full_sb_empty", 32'(sb.size()), 32'(0));
    chk("full_inst_pulses", 32'(inst_cnt - base_inst), 32'(6));
    chk("full_done_pulses", 32'(done_cnt - base_done), 32'(1));

    // Backpressure on frame 2
    for (int i = 0; i < 6; i++) sb.push_back({3'(i), ch_vals[i]});
    start_readout(6'h3F);
    n = 0;
    while (!(WORD_VALID && REG_ID == 3'd1) && n < 100) begin tick(); n++; end
    chk("bp_f1_valid", 32'(WORD_VALID), 32'(1));
    tick();
    WORD_READY = 1'b0;
    n = 0;
    while (!WORD_VALID && n < 100) begin tick(); n++; end
    chk("bp_f2_word", 32'(WORD_OUT), 32'(10'h2AA));
    chk("bp_f2_id", 32'(REG_ID), 32'(2));
    repeat (7) tick();
    chk("bp_still_valid", 32'(WORD_VALID), 32'(1));
    WORD_READY = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(WORD_VALID), 32'(0));
    chk("bp_next_sel", 32'(SELECT_REG), 32'(3));
    tick();
    chk("bp_next_inst", 32'(INST_READOUT), 32'(1));
    run_until_done(done_rel, valid_rel);
    $display("backpressure: done at %0d", done_rel);
    chk("bp_done_cycle", 32'(done_rel), 32'(86));
    tick();
    chk("bp_sb_empty", 32'(sb.size()), 32'(0));

    // Sparse mask, then empty mask
    ch_vals[1] = 10'h0F0; ch_vals[5] = 10'h30C;
    sb.push_back({3'd1, 10'h0F0});
    sb.push_back({3'd5, 10'h30C});
    base_inst = inst_cnt;
    start_readout(6'b100010);
    run_until_done(done_rel, valid_rel);
    $display("sparse: done at %0d", done_rel);
    chk("sparse_done_cycle", 32'(done_rel), 32'(27));
    tick();
    chk("sparse_inst_pulses", 32'(inst_cnt - base_inst), 32'(2));
    chk("sparse_sb_empty", 32'(sb.size()), 32'(0));

    base_inst = inst_cnt;
    start_readout(6'h00);
    run_until_done(done_rel, valid_rel);
    $display("empty mask: done at %0d", done_rel);
    chk("empty_done_cycle", 32'(done_rel), 32'(1));
    tick();
    chk("empty_inst_pulses", 32'(inst_cnt - base_inst), 32'(0));

    // Format error on frame 0, sticky past DONE, cleared by next START
    ch_vals[0] = 10'b0000100011;
    sb.push_back({3'd0, 10'h023});
    start_readout(6'h01);
    run_until_done(done_rel, valid_rel);
    chk("fmt_done_cycle", 32'(done_rel), 32'(14));
    chk("fmt_set", 32'(FMT_ERR), 32'(1));
    tick(); tick();
    chk("fmt_sticky", 32'(FMT_ERR), 32'(1));
    ch_vals[0] = 10'h005;
    sb.push_back({3'd0, 10'h005});
    start_readout(6'h01);
    chk("fmt_cleared", 32'(FMT_ERR), 32'(0));
    run_until_done(done_rel, valid_rel);
    chk("fmt_clean", 32'(FMT_ERR), 32'(0));
    tick();
    chk("fmt_sb_empty", 32'(sb.size()), 32'(0));

    // START held high throughout, including the FINISH cycle
    ch_vals[1] = 10'h155;
    sb.push_back({3'd0, 10'h005});
    sb.push_back({3'd1, 10'h155});
    base_inst = inst_cnt; base_done = done_cnt;
    REG_MASK = 6'h03;
    START = 1'b1;
    tick();
    start_cyc = cyc;
    n = 0;
    while (!DONE && n < 200) begin tick(); n++; end
    START = 1'b0;
    chk("hold_done_cycle", 32'(cyc - start_cyc), 32'(27));
    repeat (3) tick();
    chk("hold_busy_after", 32'(BUSY), 32'(0));
    chk("hold_inst_pulses", 32'(inst_cnt - base_inst), 32'(2));
    chk("hold_done_pulses", 32'(done_cnt - base_done), 32'(1));
    chk("hold_sb_empty", 32'(sb.size()), 32'(0));

    // Reset in the middle of SHIFT
    start_readout(6'h3F);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    check_reset("midrst");
    tick();
    RST = 1'b0;
    base_inst = inst_cnt; base_done = done_cnt;
    repeat (30) tick();
    chk("midrst_no_inst", 32'(inst_cnt - base_inst), 32'(0));
    chk("midrst_no_done", 32'(done_cnt - base_done), 32'(0));
    chk("midrst_idle", 32'(BUSY), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
